// File: rtl/video_timing_pkg.sv
// Shared encodings and default 720p timing for the video test-pattern source.
// Imported by the stream generator and its pattern sub-block.
package video_timing_pkg;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BAR   = 2'd3;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  function automatic int line_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_stream_gen_if.sv
// Camera-compatible luma stream bundle (vs/hs/de/Y) between source and Sobel chain.
interface video_stream_if;
  logic       ycbcr_vs;
  logic       ycbcr_hs;
  logic       ycbcr_de;
  logic [7:0] ycbcr_y;

  modport master (output ycbcr_vs, output ycbcr_hs, output ycbcr_de, output ycbcr_y);
  modport slave  (input  ycbcr_vs, input  ycbcr_hs, input  ycbcr_de, input  ycbcr_y);
endinterface

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern luma for one active pixel; the parent registers it
// and forces zero outside active video.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int XW    = 11,
  parameter int BAR_W = 16
) (
  input  logic [XW-1:0] x,
  input  logic [7:0]    y8,
  input  logic [1:0]    pattern,
  input  logic [XW-1:0] bar_x,
  output logic [7:0]    luma
);

  localparam int EW = XW + 1;

  logic [7:0]  x8;
  logic [EW-1:0] bar_end;
  logic        in_bar;

  // The bar end is one bit wider so a bar near the right edge clips instead of wrapping.
  assign x8      = 8'(x);
  assign bar_end = {1'b0, bar_x} + EW'(BAR_W);
  assign in_bar  = (x >= bar_x) && ({1'b0, x} < bar_end);

  always_comb begin
    luma = 8'h00;
    case (pattern)
      PAT_HRAMP: luma = x8;
      PAT_VRAMP: luma = y8;
      PAT_CHECK: luma = (x8[5] ^ y8[5]) ? 8'hFF : 8'h00;
      default:   luma = in_bar ? 8'hFF : 8'h10;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// Video timing and test-pattern source feeding the 3x3 window / Sobel chain.
// Raster counters, sync decode, moving-bar position and frame counter live here.
module video_stream_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int BAR_W    = 16,
  parameter int BAR_STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [1:0]     pattern_sel,
  video_stream_if.master vid,
  output logic           frame_start,
  output logic [7:0]     frame_cnt
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int HW1 = HW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW1-1:0] BAR_STEP_W = HW1'(BAR_STEP);
  localparam logic [HW1-1:0] H_ACT_W    = HW1'(H_ACTIVE);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [HW-1:0] bar_x_q, bar_x_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic          run_q, run_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          fs_q, fs_d;
  logic [7:0]    y_q, y_d;

  logic          frame_end;
  logic          boundary;
  logic          bar_wrap;
  logic [7:0]    luma;

  video_pattern_gen #(
    .XW    (HW),
    .BAR_W (BAR_W)
  ) u_pattern (
    .x       (h_q),
    .y8      (8'(v_q)),
    .pattern (pat_q),
    .bar_x   (bar_x_q),
    .luma    (luma)
  );

  // While idle the counters sit at (0,0) and every clock is a boundary sample;
  // while running the sample coincides with the wrap back to (0,0).
  always_comb begin
    frame_end   = (h_q == H_LAST) && (v_q == V_LAST);
    boundary    = !run_q || frame_end;
    bar_wrap    = ({1'b0, bar_x_q} + BAR_STEP_W) >= H_ACT_W;

    h_d         = h_q;
    v_d         = v_q;
    bar_x_d     = bar_x_q;
    frame_cnt_d = frame_cnt_q;
    run_d       = run_q;
    pat_d       = pat_q;

    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    if (run_q && frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      bar_x_d     = bar_wrap ? '0 : bar_x_q + HW'(BAR_STEP);
    end

    if (boundary) begin
      run_d = en;
      pat_d = pattern_sel;
    end

    de_d = run_q && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d = (run_q && (h_q >= HS_BEGIN) && (h_q < HS_END)) ? HS_ON : !HS_ON;
    vs_d = (run_q && (v_q >= VS_BEGIN) && (v_q < VS_END)) ? VS_ON : !VS_ON;
    y_d  = de_d ? luma : 8'h00;
    fs_d = run_q && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      bar_x_q     <= '0;
      frame_cnt_q <= 8'd0;
      run_q       <= 1'b0;
      pat_q       <= PAT_HRAMP;
      de_q        <= 1'b0;
      hs_q        <= !HS_ON;
      vs_q        <= !VS_ON;
      fs_q        <= 1'b0;
      y_q         <= 8'h00;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      bar_x_q     <= bar_x_d;
      frame_cnt_q <= frame_cnt_d;
      run_q       <= run_d;
      pat_q       <= pat_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      y_q         <= y_d;
    end
  end

  assign vid.ycbcr_vs = vs_q;
  assign vid.ycbcr_hs = hs_q;
  assign vid.ycbcr_de = de_q;
  assign vid.ycbcr_y  = y_q;
  assign frame_start  = fs_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: a small-timing instance (A) and a 64x64 inverted-sync
// instance (B) share stimulus and are checked every clock against a raster-position model.
module tb_video_stream_gen;
  import video_timing_pkg::*;

  localparam int A_HA = 8,  A_HF = 2, A_HS = 2, A_HB = 2;
  localparam int A_VA = 4,  A_VF = 1, A_VS = 1, A_VB = 1;
  localparam int A_BW = 2,  A_BS = 4;
  localparam int B_HA = 64, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 64, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_BW = 16, B_BS = 24;

  localparam int HA[2]   = '{A_HA, B_HA};
  localparam int HFP[2]  = '{A_HF, B_HF};
  localparam int HSY[2]  = '{A_HS, B_HS};
  localparam int VA[2]   = '{A_VA, B_VA};
  localparam int VFP[2]  = '{A_VF, B_VF};
  localparam int VSY[2]  = '{A_VS, B_VS};
  localparam int BW[2]   = '{A_BW, B_BW};
  localparam int BS[2]   = '{A_BS, B_BS};
  localparam int HPOL[2] = '{1, 0};
  localparam int VPOL[2] = '{1, 0};
  localparam int HT[2]   = '{A_HA + A_HF + A_HS + A_HB, B_HA + B_HF + B_HS + B_HB};
  localparam int VT[2]   = '{A_VA + A_VF + A_VS + A_VB, B_VA + B_VF + B_VS + B_VB};
  localparam int FT[2]   = '{HT[0] * VT[0], HT[1] * VT[1]};

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] pattern_sel;
  logic       fs_a, fs_b;
  logic [7:0] fc_a, fc_b;

  video_stream_if vid_a ();
  video_stream_if vid_b ();

  video_stream_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .HS_POL(1), .VS_POL(1), .BAR_W(A_BW), .BAR_STEP(A_BS)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .vid(vid_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  video_stream_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .HS_POL(0), .VS_POL(0), .BAR_W(B_BW), .BAR_STEP(B_BS)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .vid(vid_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       obs_de[2], obs_hs[2], obs_vs[2], obs_fs[2];
  logic [7:0] obs_y[2], obs_fc[2];
  assign obs_de[0] = vid_a.ycbcr_de;  assign obs_de[1] = vid_b.ycbcr_de;
  assign obs_hs[0] = vid_a.ycbcr_hs;  assign obs_hs[1] = vid_b.ycbcr_hs;
  assign obs_vs[0] = vid_a.ycbcr_vs;  assign obs_vs[1] = vid_b.ycbcr_vs;
  assign obs_y[0]  = vid_a.ycbcr_y;   assign obs_y[1]  = vid_b.ycbcr_y;
  assign obs_fs[0] = fs_a;            assign obs_fs[1] = fs_b;
  assign obs_fc[0] = fc_a;            assign obs_fc[1] = fc_b;

  int checks;
  int failures;
  bit mon_on;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic string tagOf(input int i, input string s);
    string p;
    p = (i == 0) ? "A." : "B.";
    return {p, s};
  endfunction

  // Reference model: each instance is a position within its frame plus run/pattern/bar/count.
  bit         m_run[2];
  int         m_pos[2];
  logic [1:0] m_pat[2];
  int         m_bar[2];
  int         m_fc[2];
  logic       exp_de[2], exp_hs[2], exp_vs[2], exp_fs[2];
  logic [7:0] exp_y[2];

  function automatic int px(input int i, input int pos);
    return pos % HT[i];
  endfunction

  function automatic int py(input int i, input int pos);
    return pos / HT[i];
  endfunction

  function automatic bit active(input int i, input int pos);
    return (px(i, pos) < HA[i]) && (py(i, pos) < VA[i]);
  endfunction

  function automatic bit hs_level(input int i, input bit run, input int pos);
    int h;
    h = px(i, pos);
    if (run && h >= HA[i] + HFP[i] && h < HA[i] + HFP[i] + HSY[i]) return HPOL[i] != 0;
    return HPOL[i] == 0;
  endfunction

  function automatic bit vs_level(input int i, input bit run, input int pos);
    int v;
    v = py(i, pos);
    if (run && v >= VA[i] + VFP[i] && v < VA[i] + VFP[i] + VSY[i]) return VPOL[i] != 0;
    return VPOL[i] == 0;
  endfunction

  function automatic logic [7:0] ref_luma(input int i, input int pos, input logic [1:0] pat, input int bar);
    int x, y;
    x = px(i, pos);
    y = py(i, pos);
    case (pat)
      2'd0:    return 8'(x % 256);
      2'd1:    return 8'(y % 256);
      2'd2:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
      default: return (x >= bar && x < bar + BW[i] && x < HA[i]) ? 8'hFF : 8'h10;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 1'b0;
        m_pos[i]  <= 0;
        m_pat[i]  <= 2'd0;
        m_bar[i]  <= 0;
        m_fc[i]   <= 0;
        exp_de[i] <= 1'b0;
        exp_hs[i] <= (HPOL[i] == 0);
        exp_vs[i] <= (VPOL[i] == 0);
        exp_fs[i] <= 1'b0;
        exp_y[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_de[i] <= m_run[i] && active(i, m_pos[i]);
        exp_hs[i] <= hs_level(i, m_run[i], m_pos[i]);
        exp_vs[i] <= vs_level(i, m_run[i], m_pos[i]);
        exp_fs[i] <= m_run[i] && (m_pos[i] == 0);
        exp_y[i]  <= (m_run[i] && active(i, m_pos[i])) ? ref_luma(i, m_pos[i], m_pat[i], m_bar[i]) : 8'h00;
        if (m_run[i] && m_pos[i] == FT[i] - 1) begin
          m_pos[i] <= 0;
          m_fc[i]  <= (m_fc[i] + 1) % 256;
          m_bar[i] <= (m_bar[i] + BS[i] >= HA[i]) ? 0 : m_bar[i] + BS[i];
        end else if (m_run[i]) begin
          m_pos[i] <= m_pos[i] + 1;
        end
        if (!m_run[i] || m_pos[i] == FT[i] - 1) begin
          m_run[i] <= en;
          m_pat[i] <= pattern_sel;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput(tagOf(i, "de"), 32'(obs_de[i]), 32'(exp_de[i]));
        checkOutput(tagOf(i, "hs"), 32'(obs_hs[i]), 32'(exp_hs[i]));
        checkOutput(tagOf(i, "vs"), 32'(obs_vs[i]), 32'(exp_vs[i]));
        checkOutput(tagOf(i, "y"), 32'(obs_y[i]), 32'(exp_y[i]));
        checkOutput(tagOf(i, "frame_start"), 32'(obs_fs[i]), 32'(exp_fs[i]));
        checkOutput(tagOf(i, "frame_cnt"), 32'(obs_fc[i]), 32'(m_fc[i]));
      end
    end
  end

  task automatic checkResetValues(input string phase);
    for (int i = 0; i < 2; i++) begin
      checkOutput(tagOf(i, {phase, ".de"}), 32'(obs_de[i]), 32'd0);
      checkOutput(tagOf(i, {phase, ".hs"}), 32'(obs_hs[i]), 32'(HPOL[i] == 0));
      checkOutput(tagOf(i, {phase, ".vs"}), 32'(obs_vs[i]), 32'(VPOL[i] == 0));
      checkOutput(tagOf(i, {phase, ".y"}), 32'(obs_y[i]), 32'd0);
      checkOutput(tagOf(i, {phase, ".fs"}), 32'(obs_fs[i]), 32'd0);
      checkOutput(tagOf(i, {phase, ".fc"}), 32'(obs_fc[i]), 32'd0);
    end
  endtask

  task automatic waitFrameStart(input int i, input int bound, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_fs[i] && n < bound);
    checkOutput(tag, 32'(obs_fs[i]), 32'd1);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(99) < 2) pattern_sel = 2'($urandom_range(3));
      if (en) begin
        if ($urandom_range(999) < 3) en = 1'b0;
      end else if ($urandom_range(99) < 4) begin
        en = 1'b1;
      end
    end
  endtask

  initial begin
    int n, de_n, hs_n, vs_n, fs_n;
    checks = 0;
    failures = 0;
    mon_on = 1'b0;
    en = 1'b0;
    pattern_sel = PAT_HRAMP;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");

    // Release with en already high: sample on the first edge, first pixel on the second.
    rst_n = 1'b1;
    en = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    checkOutput("start.fs_first_edge", 32'(fs_a), 32'd0);
    @(negedge clk);
    checkOutput("start.fs_second_edge", 32'(fs_a), 32'd1);
    checkOutput("start.de_second_edge", 32'(vid_a.ycbcr_de), 32'd1);
    checkOutput("start.fsB_second_edge", 32'(fs_b), 32'd1);

    n = 0; de_n = 0; hs_n = 0; vs_n = 0;
    do begin
      @(negedge clk);
      n++;
      de_n += int'(vid_a.ycbcr_de);
      hs_n += int'(vid_a.ycbcr_hs);
      vs_n += int'(vid_a.ycbcr_vs);
    end while (!fs_a && n < 300);
    checkOutput("A.frame_period", n, 98);
    checkOutput("A.de_per_frame", de_n, 32);
    checkOutput("A.hs_per_frame", hs_n, 14);
    checkOutput("A.vs_per_frame", vs_n, 14);

    pattern_sel = PAT_BAR;
    repeat (4) waitFrameStart(0, 300, "A.bar_frame");

    pattern_sel = PAT_CHECK;
    repeat (3) waitFrameStart(1, 6000, "B.check_frame");

    // Drop en and change pattern mid-frame: the frame completes, then A idles.
    pattern_sel = PAT_HRAMP;
    waitFrameStart(0, 300, "A.pre_drop");
    repeat (30) @(negedge clk);
    pattern_sel = PAT_VRAMP;
    en = 1'b0;
    fs_n = 0;
    repeat (150) begin
      @(negedge clk);
      fs_n += int'(fs_a);
    end
    checkOutput("A.idle_no_frame_start", fs_n, 0);
    checkOutput("A.idle_de", 32'(vid_a.ycbcr_de), 32'd0);
    checkOutput("A.idle_hs", 32'(vid_a.ycbcr_hs), 32'd0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("A.restart_fs_sample_edge", 32'(fs_a), 32'd0);
    @(negedge clk);
    checkOutput("A.restart_fs", 32'(fs_a), 32'd1);

    applyStimulus(30000);

    // Asynchronous reset in the middle of a line, checked before any clock edge.
    en = 1'b1;
    waitFrameStart(0, 300, "A.pre_reset");
    repeat (17) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("A.post_reset_fs_sample_edge", 32'(fs_a), 32'd0);
    @(negedge clk);
    checkOutput("A.post_reset_fs", 32'(fs_a), 32'd1);
    checkOutput("A.post_reset_fc", 32'(fc_a), 32'd0);
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/video_stream_gen.md
# video_stream_gen

Parameterised video timing and test-pattern source. It produces the vs/hs/de/Y luma stream that the edge-detection pipeline consumes, so the Sobel path can be brought up and regressed without a camera. It sits upstream of the 3x3 window/Sobel chain. Its outputs are drop-in replacements for the camera-side YCbCr stream.

## Interface
- H_ACTIVE, 1280: active pixels per line
- H_FP, 110: horizontal front porch, clocks
- H_SYNC, 40: hsync width, clocks
- H_BP, 220: horizontal back porch, clocks
- V_ACTIVE, 720: active lines per frame
- V_FP, 5: vertical front porch, lines
- V_SYNC, 5: vsync width, lines
- V_BP, 20: vertical back porch, lines
- HS_POL, 1: hsync active level
- VS_POL, 1: vsync active level
- BAR_W, 16: moving-bar width, pixels
- BAR_STEP, 4: moving-bar advance per frame, pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  run enable; sampled only at frame boundary
- pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 checkerboard, 3 moving bar
- ycbcr_vs  out  1  vertical sync
- ycbcr_hs  out  1  horizontal sync
- ycbcr_de  out  1  active-video enable
- ycbcr_y  out  8  luma; 0x00 outside de
- frame_start  out  1  one-clock pulse coincident with first de of a frame
- frame_cnt  out  8  completed-frame counter, wraps 255->0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order is active, FP, sync, BP, both axes.
- h counts 0..H_TOTAL-1. v increments when h wraps. v wraps at V_TOTAL-1 -> 0, and frame_cnt increments at that point.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- hs active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vs active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vs changes only with h = 0.
- Inactive sync level is !POL.
- Frame boundary is (h,v) = (0,0).
  - en and pattern_sel are latched only at the boundary.
  - en low at the boundary: counters hold at (0,0), and outputs stay idle (de 0, syncs inactive, y 0).
  - en falling mid-frame has no effect; the frame completes.
- Patterns (active region only; x = h, y = v):
  - 0: Y = x[7:0]
  - 1: Y = y[7:0]
  - 2: Y = 0xFF if x[5]^y[5], else 0x00 (32x32 squares)
  - 3: Y = 0xFF if bar_x <= x < bar_x+BAR_W, else 0x10. A bar that runs past H_ACTIVE is clipped, not wrapped. bar_x advances by BAR_STEP at each frame boundary and resets to 0 when bar_x+BAR_STEP >= H_ACTIVE.
- Counter widths: clog2(H_TOTAL) and clog2(V_TOTAL). Ramp values truncate to 8 bits.

## Timing
- All outputs registered. Counter state (h,v) at cycle n drives outputs at cycle n+1: one clock latency.
- Reset values:
  - h, v, bar_x, frame_cnt = 0
  - de, frame_start = 0; y = 0x00
  - hs = !HS_POL; vs = !VS_POL
  - latched pattern = 0, latched en = 0
- After rst_n release with en = 1, the first boundary sample is at the first clk edge. The first de and frame_start appear at the following edge.
- frame_start pulses once per frame and never fires while idle.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). Deassertion restarts at (0,0).
- A pattern_sel change mid-frame takes effect on the next frame only.

## Structure
- Package video_timing_pkg holds:
  - pattern_sel encodings (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_BAR)
  - the default 720p timing constants
- Sub-module video_pattern_gen: combinational Y from (x, y, pattern, bar_x), registered in the parent.
- Counters, sync decode, bar_x and frame_cnt stay in video_stream_gen.

## Test plan
Small-timing bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), BAR_W 2, BAR_STEP 4.
- Reset then en = 1, pattern 0:
  - de high 8 clocks per line, 4 lines
  - Y = 0..7 each line
  - hs high on h = 10..11
  - vs high for line v = 5
  - frame period 98 clocks
- Pattern 2 with H_ACTIVE 64, V_ACTIVE 64:
  - Y = 0x00 at (0,0), 0xFF at (32,0), 0x00 at (32,32)
  - Y = 0x00 outside de
- Pattern 3 over 3 frames: bar at x = 0..1, then 4..5, then back to 0..1 (4+4 >= 8 wrap). Background 0x10.
- Toggle pattern_sel and drop en mid-frame:
  - current frame unchanged and completed
  - outputs then idle
  - frame_cnt stops
  - re-raising en restarts with frame_start one clock after the boundary sample
- Assert rst_n low mid-line:
  - outputs take reset values without waiting for a clock
  - after release the frame restarts at (0,0)
  - frame_cnt = 0
- HS_POL = 0, VS_POL = 0: sync waveforms are inverted, and de/Y are unchanged.
